// File: rtl/aes_inv_key_sched.sv
// Inverse AES-128 key schedule: loaded with round key 10, then steps back one
// round key per accepted `next`, deriving each earlier key on the fly.
module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic         next,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Rcon is indexed by the round being left, not the one being entered
  function automatic logic [7:0] f_rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       r_state, w_state_nxt;
  logic [127:0] r_key, w_key_nxt;
  logic [3:0]   r_idx, w_idx_nxt;
  logic         r_done, w_done_nxt;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_w0p, w_w1p, w_w2p, w_w3p;
  logic [31:0]  w_rot, w_sub;
  logic [127:0] w_prev_key;

  assign w_w0 = r_key[127:96];
  assign w_w1 = r_key[95:64];
  assign w_w2 = r_key[63:32];
  assign w_w3 = r_key[31:0];

  assign w_w3p = w_w3 ^ w_w2;
  assign w_w2p = w_w2 ^ w_w1;
  assign w_w1p = w_w1 ^ w_w0;
  assign w_rot = {w_w3p[23:0], w_w3p[31:24]};
  assign w_sub = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]};
  assign w_w0p = w_w0 ^ w_sub ^ {f_rcon(r_idx), 24'h0};
  assign w_prev_key = {w_w0p, w_w1p, w_w2p, w_w3p};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_key_nxt   = last_key;
          w_idx_nxt   = 4'd10;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (next) begin
          if (r_idx != 4'd0) begin
            w_key_nxt = w_prev_key;
            w_idx_nxt = r_idx - 4'd1;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign round_key = r_key;
  assign round_idx = r_idx;
  assign key_valid = (r_state == S_ACTIVE);
  assign busy      = (r_state == S_ACTIVE);
  assign done      = r_done;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: reference round keys come from a forward
// FIPS-197 expansion using an S-box computed from GF(2^8) inversion.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst, start, next;
  logic [127:0] last_key;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid, busy, done;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] rk [0:10];

  aes_inv_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .last_key(last_key), .next(next),
    .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t = {x, x} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b   = 8'(v);
      logic [7:0] inv = 8'h01;
      if (b == 8'h00) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, b);
      sbox_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward FIPS-197 expansion; rk[r] is round key r
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_key(input string tag, input int r);
    chk({tag, "_idx"},   128'(round_idx), 128'(r));
    chk({tag, "_key"},   round_key, rk[r]);
    chk({tag, "_valid"}, 128'(key_valid), 128'(1));
    chk({tag, "_busy"},  128'(busy), 128'(1));
    chk({tag, "_done"},  128'(done), 128'(0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_key"},   round_key, 128'h0);
    chk({tag, "_idx"},   128'(round_idx), 128'h0);
    chk({tag, "_valid"}, 128'(key_valid), 128'h0);
    chk({tag, "_busy"},  128'(busy), 128'h0);
    chk({tag, "_done"},  128'(done), 128'h0);
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"},  128'(done), 128'(1));
    chk({tag, "_valid"}, 128'(key_valid), 128'(0));
    chk({tag, "_idx"},   128'(round_idx), 128'(0));
    chk({tag, "_key"},   round_key, rk[0]);
  endtask

  // Assumes round 10 is visible; holds next high through the done pulse
  task automatic sweep_full(input string tag);
    next = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      check_key(tag, r);
      tick();
    end
    check_done(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] k;
    int unsigned  gap;
    rst = 1'b1; start = 1'b0; next = 1'b0; last_key = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    tick();

    // FIPS-197 A.1 sweep, next held high from the start
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    last_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    start = 1'b1;
    next  = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 10; r >= 0; r--) begin
      check_key("a1", r);
      if (r == 9) chk("a1_r9_const", round_key, 128'hac7766f319fadc2128d12941575c006e);
      if (r == 0) chk("a1_r0_const", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      tick();
    end
    check_done("a1_end");
    next = 1'b0;
    tick();
    chk("a1_done_pulse", 128'(done), 128'(0));

    // next while idle is ignored
    next = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_next_valid", 128'(key_valid), 128'(0));
      chk("idle_next_key", round_key, rk[0]);
    end
    next = 1'b0;

    // random key, random stalls, ignored start at round 5
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k);
    last_key = rk[10];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 10; r >= 0; r--) begin
      check_key("stall", r);
      if (r == 5) begin
        start = 1'b1;
        last_key = ~rk[10];
        tick();
        start = 1'b0;
        check_key("ign_start", r);
      end
      gap = $urandom_range(0, 5);
      repeat (gap) begin
        tick();
        check_key("stall_hold", r);
      end
      next = 1'b1;
      tick();
      next = 1'b0;
    end
    check_done("stall_end");

    // back-to-back start in the done cycle (FIPS-197 C.1)
    last_key = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    start = 1'b1;
    tick();
    start = 1'b0;
    expand(128'h000102030405060708090a0b0c0d0e0f);
    chk("b2b_done_low", 128'(done), 128'(0));
    sweep_full("b2b");
    chk("b2b_r0_const", round_key, 128'h000102030405060708090a0b0c0d0e0f);
    next = 1'b0;
    tick();

    // asynchronous reset mid-sweep at round 4
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k);
    last_key = rk[10];
    start = 1'b1;
    tick();
    start = 1'b0;
    next = 1'b1;
    repeat (6) tick();
    next = 1'b0;
    check_key("pre_rst", 4);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    start = 1'b1;
    next  = 1'b1;
    repeat (2) tick();
    check_zero("rst_held");
    start = 1'b0;
    next  = 1'b0;
    rst   = 1'b0;
    tick();
    check_zero("post_rst");

    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k);
    last_key = rk[10];
    start = 1'b1;
    tick();
    start = 1'b0;
    sweep_full("after_rst");
    next = 1'b0;
    tick();
    chk("after_rst_done_pulse", 128'(done), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Inverse AES-128 key schedule for the decryption datapath. It is loaded with the final (round-10) round key and walks the expansion backwards. It presents round keys 10, 9, … 0 one at a time to the inverse-cipher round-key XOR stage under a valid/next handshake. No 1408-bit key store is needed: each earlier round key is derived on the fly from the current one.

## Interface
- No parameters; AES-128 only.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to load `last_key`; honoured only while idle (`busy`=0).
- `last_key`  in  128  round-10 key; `[127:96]` = word w40, `[31:0]` = w43; bytes big-endian within a word, per FIPS-197.
- `next`  in  1  consumer has taken the current key; honoured only while `key_valid`=1.
- `round_key`  out  128  current round key, registered.
- `round_idx`  out  4  round number of `round_key` (10 down to 0), registered.
- `key_valid`  out  1  `round_key`/`round_idx` are valid.
- `busy`  out  1  a sweep is in progress (equals `key_valid`).
- `done`  out  1  one-cycle pulse after round key 0 is consumed.

## Operation
- Two states.
  - IDLE: `key_valid`=0.
  - ACTIVE: `key_valid`=1.
- IDLE, `start`=1:
  - Register `last_key` into `round_key`.
  - Set `round_idx`=10.
  - Go to ACTIVE.
- IDLE, `start`=0: hold all registers.
- ACTIVE, `next`=0: hold all registers (stall of any length).
- ACTIVE, `next`=1, `round_idx`=r>0: replace `round_key` with round key r−1 and set `round_idx`=r−1.
- Backward step, with current words w0..w3 (`w0`=`[127:96]`):
  - w3' = w3 ^ w2
  - w2' = w2 ^ w1
  - w1' = w1 ^ w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r], 24'h0}
- RotWord({a,b,c,d}) = {b,c,d,a}.
- SubWord applies the forward AES S-box to each byte. The forward S-box is contained in this block: a 256-entry lookup, 4 instances.
- Rcon[r], r=1..10: 01,02,04,08,10,20,40,80,1b,36. Rcon is indexed by the round being left (r), not the round being entered.
- ACTIVE, `next`=1, `round_idx`=0:
  - Go to IDLE.
  - `key_valid`←0.
  - `done`←1 for exactly one cycle.
  - `round_key` keeps round key 0 (the original cipher key); `round_idx` stays 0.
- `start` while ACTIVE: ignored; no reload, no corruption.
- `next` while IDLE: ignored.
- All arithmetic is XOR and lookup; no carries. `round_idx` never wraps below 0.

## Timing
- Reset value of every output is 0: `round_key`=128'h0, `round_idx`=0, `key_valid`=0, `busy`=0, `done`=0. State resets to IDLE.
- `start` sampled at edge E → `key_valid`=1 and round-10 key visible after E (latency 1 cycle).
- `next` sampled high at edge E → new key visible after E. Throughput is one key per cycle with `next` held high.
- Full sweep with `next` constantly high, `start` at edge E0:
  - Keys 10..0 are valid after edges E0..E10.
  - `done`=1 after E11, together with `key_valid`=0.
- `start` in the same cycle `done`=1 is accepted (state is IDLE). The new sweep's round-10 key appears after the following edge, and `done` returns to 0.
- `rst` asserted mid-sweep clears all outputs immediately (asynchronous) and returns to IDLE. No `done` pulse. Operation resumes only on a new `start` after `rst` deasserts.
- The backward-step logic is purely combinational from the `round_key` register into the next-state mux: one S-box plus XOR depth per cycle.

## Test plan
- Reset: assert `rst` mid-clock with outputs nonzero → all outputs 0 before the next edge; `next`/`start` pulses during reset → no effect.
- FIPS-197 A.1 sweep: `last_key`=d014f9a8c9ee2589e13f0cc8b6630ca6, `start`, then `next` held high → `round_idx` 10, 9 … 0. Round 9 key = ac7766f319fadc2128d12941575c006e. Round 0 key = 2b7e151628aed2a6abf7158809cf4f3c. `done` is a single pulse one cycle after round 0 is consumed.
- Stalls: random `next` gaps (0–5 cycles) during the same sweep → identical key sequence; `round_key` stable while `next`=0.
- Ignored inputs: `start` with a different `last_key` at round 5 → sweep continues unaltered. `next` pulses while IDLE → `key_valid` stays 0 and `round_key` unchanged.
- Back-to-back: `start` asserted in the `done` cycle with `last_key`=13111d7fe3944a17f307a78b4d2b30c5 (FIPS-197 C.1) → round 0 key = 000102030405060708090a0b0c0d0e0f.
- Reset mid-sweep at `round_idx`=4 → IDLE with no `done`. A subsequent `start` yields a full correct sweep from round 10.
